// File: rtl/ahb_bridge_pkg.sv
// ahb_bridge_pkg: shared transfer encodings, response codes, decode regions and FSM states
// for the AHB side of the AHB2APB bridge.
package ahb_bridge_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] MAX_HSIZE = 3'd2;

    // Region i drives be_sel[i]; index 0 is the lowest window.
    localparam int NUM_REGIONS = 3;
    localparam logic [NUM_REGIONS-1:0][31:0] REGION_BASE  = {32'h8800_0000, 32'h8400_0000, 32'h8000_0000};
    localparam logic [NUM_REGIONS-1:0][31:0] REGION_LIMIT = {32'h8BFF_FFFF, 32'h87FF_FFFF, 32'h83FF_FFFF};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_REQ,
        ST_DONE,
        ST_ERR1,
        ST_ERR2
    } state_e;

endpackage

// File: rtl/ahb_addr_decoder.sv
// ahb_addr_decoder: maps an address-phase haddr/hsize onto a one-hot slave select;
// an unmapped address or an oversized transfer yields no select and no hit.
module ahb_addr_decoder
    import ahb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int NUM_SEL = 3
) (
    input  logic [ADDR_W-1:0]  haddr,
    input  logic [2:0]         hsize,
    output logic [NUM_SEL-1:0] sel,
    output logic               hit
);

    logic size_ok;

    assign size_ok = hsize <= MAX_HSIZE;

    for (genvar i = 0; i < NUM_SEL; i++) begin : g_sel
        if (i < NUM_REGIONS) begin : g_region
            assign sel[i] = size_ok
                         && haddr >= ADDR_W'(REGION_BASE[i])
                         && haddr <= ADDR_W'(REGION_LIMIT[i]);
        end else begin : g_none
            assign sel[i] = 1'b0;
        end
    end

    assign hit = |sel;

endmodule

// File: rtl/ahb_slave_frontend.sv
// ahb_slave_frontend: AHB responder of the AHB2APB bridge; decodes and latches each transfer,
// hands it to the APB back-end over be_req/be_ack and returns OKAY/ERROR with wait states.
module ahb_slave_frontend
    import ahb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SEL = 3
) (
    input  logic               hclk,
    input  logic               hreset,
    input  logic [ADDR_W-1:0]  haddr,
    input  logic               hwrite,
    input  logic [1:0]         htrans,
    input  logic [2:0]         hsize,
    input  logic               hreadyin,
    input  logic [DATA_W-1:0]  hwdata,
    output logic [DATA_W-1:0]  hrdata,
    output logic               hreadyout,
    output logic [1:0]         hresp,
    output logic               be_req,
    output logic [ADDR_W-1:0]  be_addr,
    output logic               be_write,
    output logic [2:0]         be_size,
    output logic [NUM_SEL-1:0] be_sel,
    output logic [DATA_W-1:0]  be_wdata,
    input  logic               be_ack,
    input  logic [DATA_W-1:0]  be_rdata
);

    state_e             state;
    logic [NUM_SEL-1:0] sel;
    logic               hit;
    logic               valid;

    ahb_addr_decoder #(
        .ADDR_W (ADDR_W),
        .NUM_SEL(NUM_SEL)
    ) u_decoder (
        .haddr(haddr),
        .hsize(hsize),
        .sel  (sel),
        .hit  (hit)
    );

    // hreadyout is only high in the states that may sample a new address phase.
    assign valid = hreadyin && hreadyout && (htrans == HT_NONSEQ || htrans == HT_SEQ);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_IDLE;
            hreadyout <= 1'b1;
            hresp     <= HRESP_OKAY;
            hrdata    <= '0;
            be_req    <= 1'b0;
            be_addr   <= '0;
            be_write  <= 1'b0;
            be_size   <= '0;
            be_sel    <= '0;
            be_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (valid && hit) begin
                        state     <= ST_DATA;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_OKAY;
                        be_addr   <= haddr;
                        be_write  <= hwrite;
                        be_size   <= hsize;
                        be_sel    <= sel;
                    end else if (valid) begin
                        state     <= ST_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end else begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
                ST_DATA: begin
                    be_wdata <= hwdata;
                    be_req   <= 1'b1;
                    state    <= ST_REQ;
                end
                ST_REQ: begin
                    if (be_ack) begin
                        be_req    <= 1'b0;
                        hreadyout <= 1'b1;
                        state     <= ST_DONE;
                        if (!be_write) hrdata <= be_rdata;
                    end
                end
                ST_ERR1: begin
                    hreadyout <= 1'b1;
                    state     <= ST_ERR2;
                end
                default: begin
                    state     <= ST_IDLE;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                    be_req    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_slave_frontend.sv
// tb_ahb_slave_frontend: pipelined AHB master, back-end responder and scoreboard queues
// checking responses, wait states and back-end requests of ahb_slave_frontend.
module tb_ahb_slave_frontend;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr, hwdata, hrdata, be_addr, be_wdata, be_rdata;
    logic        hwrite, hreadyin, hreadyout, be_req, be_write, be_ack;
    logic [1:0]  htrans, hresp;
    logic [2:0]  hsize, be_size, be_sel;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } cmd_t;

    typedef struct {
        int          len;
        logic [1:0]  resp;
        logic [31:0] rd;
    } rsp_t;

    cmd_t        cmd_q[$];
    cmd_t        be_q[$];
    rsp_t        rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          req_rises = 0;
    int          exp_cycles = 0;
    int          req_cnt = 0;
    logic        noise = 1'b0;
    logic        have = 1'b0;
    cmd_t        cur;
    logic [31:0] last_rd = '0;

    ahb_slave_frontend dut (
        .hclk     (hclk),
        .hreset   (hreset),
        .haddr    (haddr),
        .hwrite   (hwrite),
        .htrans   (htrans),
        .hsize    (hsize),
        .hreadyin (hreadyin),
        .hwdata   (hwdata),
        .hrdata   (hrdata),
        .hreadyout(hreadyout),
        .hresp    (hresp),
        .be_req   (be_req),
        .be_addr  (be_addr),
        .be_write (be_write),
        .be_size  (be_size),
        .be_sel   (be_sel),
        .be_wdata (be_wdata),
        .be_ack   (be_ack),
        .be_rdata (be_rdata)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decode: 64 MB windows counted up from 0x8000_0000.
    function automatic logic [2:0] model_sel(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] idx;
        if (s > 3'd2 || a < 32'h8000_0000) return 3'b000;
        idx = (a - 32'h8000_0000) >> 26;
        return idx < 3 ? 3'(3'b001 << idx) : 3'b000;
    endfunction

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t,
                       input logic [31:0] wd, input int d, input logic [31:0] rd);
        cmd_t c;
        c.addr = a; c.write = w; c.size = s; c.trans = t; c.wdata = wd; c.delay = d; c.rdata = rd;
        cmd_q.push_back(c);
        exp_cycles += model_sel(a, s) != 3'b000 ? d + 2 : 2;
    endtask

    task automatic expect_cmd(input cmd_t c);
        rsp_t r;
        if (model_sel(c.addr, c.size) != 3'b000) begin
            be_q.push_back(c);
            if (!c.write) last_rd = c.rdata;
            r.len = c.delay + 2;
            r.resp = 2'b00;
        end else begin
            r.len = 2;
            r.resp = 2'b01;
        end
        r.rd = last_rd;
        rsp_q.push_back(r);
    endtask

    // Drives cmd_q as a pipelined burst; each data phase is scored when hreadyout returns high.
    task automatic run_cmds(input string tag);
        int         cyc = 0;
        int         len = 0;
        logic       busy = 1'b0;
        logic [2:0] first = '0;
        cmd_t       dp;
        rsp_t       r;
        while ((cmd_q.size() > 0 || busy) && cyc < 300) begin
            @(negedge hclk);
            cyc++;
            if (busy) begin
                len++;
                if (len == 1) first = {hreadyout, hresp};
                if (hreadyout) begin
                    r = rsp_q.pop_front();
                    check({tag, "_len"}, 32'(len), 32'(r.len));
                    check({tag, "_first"}, 32'(first), 32'({1'b0, r.resp}));
                    check({tag, "_hresp"}, 32'(hresp), 32'(r.resp));
                    check({tag, "_hrdata"}, hrdata, r.rd);
                    busy = 1'b0;
                end else begin
                    hwdata = dp.wdata;
                end
            end
            if (hreadyout) begin
                if (cmd_q.size() > 0) begin
                    dp = cmd_q.pop_front();
                    expect_cmd(dp);
                    haddr = dp.addr;
                    hwrite = dp.write;
                    hsize = dp.size;
                    htrans = dp.trans;
                    busy = 1'b1;
                    len = 0;
                end else begin
                    htrans = 2'b00;
                end
            end
        end
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cycles + 1));
        exp_cycles = 0;
        cmd_q.delete();
        rsp_q.delete();
    endtask

    // Back-end model: scores be_* on every request cycle and acks after the scripted delay.
    initial begin
        be_ack = 1'b0;
        be_rdata = '0;
        forever begin
            @(negedge hclk);
            if (hreset || !be_req) begin
                req_cnt = 0;
                be_ack = noise;
                be_rdata = noise ? 32'hBAD0_BAD0 : 32'h0;
            end else begin
                if (req_cnt == 0) begin
                    req_rises++;
                    have = be_q.size() > 0;
                    check("be_req_expected", 32'(have), 32'd1);
                    if (have) cur = be_q.pop_front();
                end
                req_cnt++;
                if (have) begin
                    check("be_addr", be_addr, cur.addr);
                    check("be_sel", 32'(be_sel), 32'(model_sel(cur.addr, cur.size)));
                    check("be_write", 32'(be_write), 32'(cur.write));
                    check("be_size", 32'(be_size), 32'(cur.size));
                    check("be_wdata", be_wdata, cur.wdata);
                    be_ack = req_cnt >= cur.delay;
                    be_rdata = cur.rdata;
                end else begin
                    be_ack = 1'b1;
                    be_rdata = '0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int n;
        logic [31:0] a;
        hreset = 1'b1;
        haddr = '0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd0; hreadyin = 1'b1; hwdata = '0;
        repeat (2) @(negedge hclk);
        check("rst_ctrl", 32'({hreadyout, hresp, be_req, be_write, be_sel, be_size}), 32'h400);
        check("rst_hrdata", hrdata, 32'h0);
        check("rst_be_addr", be_addr, 32'h0);
        check("rst_be_wdata", be_wdata, 32'h0);
        hreset = 1'b0;
        @(negedge hclk);

        noise = 1'b1;
        add(32'h8000_0010, 1'b1, 3'd2, 2'b10, 32'hDEAD_BEEF, 1, 32'h0);
        run_cmds("wr");
        check("wr_be_sel_held", 32'(be_sel), 32'h1);
        check("wr_be_wdata_held", be_wdata, 32'hDEAD_BEEF);
        noise = 1'b0;

        add(32'h8400_0004, 1'b0, 3'd2, 2'b10, 32'h5555_AAAA, 4, 32'h1234_5678);
        run_cmds("rd");

        r0 = req_rises;
        add(32'h9000_0000, 1'b1, 3'd2, 2'b10, 32'h0BAD_0001, 1, 32'h0);
        add(32'h8800_0000, 1'b1, 3'd3, 2'b10, 32'h0BAD_0002, 1, 32'h0);
        run_cmds("err");
        check("err_no_req", 32'(req_rises - r0), 32'd0);

        r0 = req_rises;
        add(32'h8800_0000, 1'b1, 3'd2, 2'b10, 32'hA5A5_0001, 1, 32'h0);
        add(32'h8800_0004, 1'b1, 3'd2, 2'b11, 32'hA5A5_0002, 1, 32'h0);
        run_cmds("b2b");
        check("b2b_reqs", 32'(req_rises - r0), 32'd2);

        r0 = req_rises;
        haddr = 32'h8000_0000; hwrite = 1'b1; hsize = 3'd2;
        for (int i = 0; i <= 6; i++) begin
            @(negedge hclk);
            if (i > 0) check("idle_bus", 32'({hreadyout, hresp, be_req}), 32'h8);
            htrans = i < 2 ? 2'b00 : i < 4 ? 2'b01 : 2'b10;
            hreadyin = i < 4;
        end
        htrans = 2'b00;
        hreadyin = 1'b1;
        check("idle_no_req", 32'(req_rises - r0), 32'd0);

        noise = 1'b1;
        add(32'h83FF_FFFC, 1'b0, 3'd2, 2'b10, 32'h0, 1, 32'hCAFE_0001);
        add(32'h8BFF_FFFC, 1'b1, 3'd0, 2'b10, 32'h0000_00EE, 2, 32'h0);
        add(32'h8C00_0000, 1'b1, 3'd2, 2'b10, 32'h1, 1, 32'h0);
        add(32'h7FFF_FFFC, 1'b0, 3'd2, 2'b10, 32'h2, 1, 32'h0);
        add(32'h8400_0000, 1'b0, 3'd1, 2'b10, 32'h3, 3, 32'hCAFE_0002);
        run_cmds("edge");
        noise = 1'b0;

        be_q.push_back('{32'h8000_0020, 1'b1, 3'd2, 2'b10, 32'h1111_2222, 50, 32'h0});
        @(negedge hclk);
        haddr = 32'h8000_0020; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hwdata = 32'h1111_2222;
        @(negedge hclk);
        htrans = 2'b00;
        n = 0;
        while (!be_req && n < 10) begin
            @(negedge hclk);
            n++;
        end
        check("mid_req_seen", 32'(be_req), 32'd1);
        @(negedge hclk);
        hreset = 1'b1;
        #1;
        check("mid_rst_out", 32'({hreadyout, hresp, be_req}), 32'h8);
        check("mid_rst_hrdata", hrdata, 32'h0);
        last_rd = '0;
        be_q.delete();
        @(negedge hclk);
        hreset = 1'b0;
        add(32'h8800_0008, 1'b0, 3'd2, 2'b10, 32'h0, 2, 32'hCAFE_F00D);
        run_cmds("post_rst");

        for (int i = 0; i < 8; i++) begin
            n = $urandom_range(0, 4);
            a = n == 4 ? 32'h9000_0000 : 32'h8000_0000 + (32'(n) << 26) + (32'($urandom_range(0, 255)) << 2);
            add(a, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 2'b10, $urandom, $urandom_range(1, 3), $urandom);
        end
        run_cmds("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
